// File: rtl/evo_pkg.sv
// Shared types and default geometry for the generation scheduler.
package evo_pkg;
  localparam int DEF_M     = 5;
  localparam int DEF_N     = 5;
  localparam int DEF_WIDTH = 12;
  localparam int CELLS     = DEF_M * DEF_N;

  typedef logic [2*DEF_WIDTH-1:0] addr_t;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_LAUNCH, S_EVOLVE, S_SWAP, S_CLEAR
  } evo_state_t;
endpackage

// File: rtl/evo_scheduler_gen_timer.sv
// Prescaled countdown: done is high in the last of ticks*TICK_CYCLES cycles after load.
module gen_timer #(
  parameter int TICK_CYCLES = 100000,
  parameter int TICK_W      = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [TICK_W-1:0] ticks,
  output logic              done
);
  localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_CYCLES - 1);

  logic [PW-1:0]     pre;
  logic [TICK_W-1:0] tk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre <= '0;
      tk  <= '0;
    end else if (load) begin
      pre <= '0;
      tk  <= ticks;
    end else if (tk != '0) begin
      if (pre == PRE_LAST) begin
        pre <= '0;
        tk  <= tk - 1'b1;
      end else begin
        pre <= pre + 1'b1;
      end
    end
  end

  assign done = (tk == TICK_W'(1)) && (pre == PRE_LAST);
endmodule

// File: rtl/evo_scheduler.sv
// Generation controller: launches engine generations, counts write strobes,
// swaps buffers, and owns the front-buffer write port for clears and edits.
module evo_scheduler
  import evo_pkg::*;
#(
  parameter int P_PARAM_M      = DEF_M,
  parameter int P_PARAM_N      = DEF_N,
  parameter int WIDTH          = DEF_WIDTH,
  parameter int TICK_CYCLES    = 100000,
  parameter int TIMEOUT_CYCLES = 16 * P_PARAM_M * P_PARAM_N
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic               step_req,
  input  logic               clear_req,
  input  logic [3:0]         period_sel,
  input  logic               edit_req,
  input  logic [2*WIDTH-1:0] edit_pos,
  input  logic               edit_val,
  output logic               edit_gnt,
  input  logic               eng_wden,
  output logic               evo_en,
  output logic               eng_restart,
  output logic               buf_sel,
  output logic               ram_we,
  output logic [2*WIDTH-1:0] ram_addr,
  output logic               ram_wdata,
  output logic               busy,
  output logic [15:0]        gen_count,
  output logic               err
);
  localparam int NCELLS = P_PARAM_M * P_PARAM_N;
  localparam int AW     = 2 * WIDTH;
  localparam int CW     = $clog2(NCELLS + 1);
  localparam int TW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST_CELL = CW'(NCELLS - 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(NCELLS - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  evo_state_t    state;
  logic [CW-1:0] cell_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          t_load, t_done;
  logic [4:0]    t_ticks;

  // The countdown is (re)loaded on every entry into WAIT.
  assign t_load  = !clear_req && run && (state == S_IDLE || state == S_SWAP);
  assign t_ticks = {1'b0, period_sel} + 5'd1;

  gen_timer #(.TICK_CYCLES(TICK_CYCLES), .TICK_W(5)) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .load (t_load),
    .ticks(t_ticks),
    .done (t_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      evo_en      <= 1'b0;
      buf_sel     <= 1'b0;
      gen_count   <= '0;
      err         <= 1'b0;
      busy        <= 1'b0;
      ram_we      <= 1'b0;
      ram_addr    <= '0;
      ram_wdata   <= 1'b0;
      edit_gnt    <= 1'b0;
      eng_restart <= 1'b0;
      cell_cnt    <= '0;
      tmo_cnt     <= '0;
    end else begin
      eng_restart <= 1'b0;
      edit_gnt    <= 1'b0;
      if (clear_req && state != S_CLEAR) begin
        // A live generation is abandoned: reset the engine, never swap.
        eng_restart <= (state == S_LAUNCH || state == S_EVOLVE || state == S_SWAP);
        state       <= S_CLEAR;
        busy        <= 1'b1;
        ram_we      <= 1'b1;
        ram_addr    <= '0;
        ram_wdata   <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            ram_we <= 1'b0;
            if (step_req && !run) begin
              state <= S_LAUNCH;
              busy  <= 1'b1;
            end else if (run) begin
              state <= S_WAIT;
            end else if (edit_req && !edit_gnt) begin
              ram_we    <= 1'b1;
              ram_addr  <= edit_pos;
              ram_wdata <= edit_val;
              edit_gnt  <= 1'b1;
            end
          end
          S_WAIT: begin
            ram_we <= 1'b0;
            if (!run) begin
              state <= S_IDLE;
            end else if (t_done) begin
              state <= S_LAUNCH;
              busy  <= 1'b1;
            end else if (edit_req && !edit_gnt) begin
              ram_we    <= 1'b1;
              ram_addr  <= edit_pos;
              ram_wdata <= edit_val;
              edit_gnt  <= 1'b1;
            end
          end
          S_LAUNCH: begin
            evo_en   <= ~evo_en;
            cell_cnt <= '0;
            tmo_cnt  <= '0;
            state    <= S_EVOLVE;
          end
          S_EVOLVE: begin
            tmo_cnt <= tmo_cnt + 1'b1;
            if (tmo_cnt == TMO_LAST) begin
              err         <= 1'b1;
              eng_restart <= 1'b1;
              busy        <= 1'b0;
              state       <= S_IDLE;
            end else if (eng_wden) begin
              if (cell_cnt == LAST_CELL) begin
                // Swap lands the cycle after the final strobe.
                buf_sel   <= ~buf_sel;
                gen_count <= gen_count + 1'b1;
                state     <= S_SWAP;
              end else begin
                cell_cnt <= cell_cnt + 1'b1;
              end
            end
          end
          S_SWAP: begin
            busy  <= 1'b0;
            state <= run ? S_WAIT : S_IDLE;
          end
          S_CLEAR: begin
            if (ram_addr == LAST_ADDR) begin
              ram_we      <= 1'b0;
              err         <= 1'b0;
              gen_count   <= '0;
              eng_restart <= 1'b1;
              busy        <= 1'b0;
              state       <= S_IDLE;
            end else begin
              ram_addr <= ram_addr + 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule
